axil_write_slave: RTL and testbench
===================================

# axil_write_slave

AXI4-Lite write-side responder: accepts write address (AW) and write data (W) beats in either order, commits the data with byte strobes into a small internal register bank, and returns a write response (B). It is the far end of our AXI-Lite write master and mates directly with its AW channel outputs. The register bank is exported flat for use by downstream control logic.

## Interface
- NUM_REGS, 8: number of 32-bit registers; power of two, 2..256.
- ADDR_LSB, 2: byte-offset bits ignored in decode (word addressing).

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- awaddr  input  32  write address.
- awcache  input  4  accepted, ignored.
- awprot  input  3  accepted, ignored.
- awvalid  input  1  AW valid.
- awready  output  1  AW ready.
- wdata  input  32  write data.
- wstrb  input  4  byte strobes; bit i enables wdata[8i+7:8i].
- wvalid  input  1  W valid.
- wready  output  1  W ready.
- bresp  output  2  write response; 2'b00 OKAY, 2'b10 SLVERR.
- bvalid  output  1  B valid.
- bready  input  1  B ready.
- regs  output  32*NUM_REGS  register bank; register k at [32k+31:32k].
- wr_pulse  output  1  one-cycle pulse on each committed write.
- wr_index  output  $clog2(NUM_REGS)  index of last committed write; valid with wr_pulse.

## Operation
- States: IDLE (collecting), COMMIT (one cycle), RESP (bvalid high).
- IDLE: awready = !aw_held; wready = !w_held. AW handshake (awvalid & awready) latches awaddr, sets aw_held. W handshake latches wdata/wstrb, sets w_held. Both may occur in the same cycle.
- IDLE -> COMMIT when aw_held & w_held (both held after the edge). awready = wready = 0 outside IDLE.
- Decode: word = awaddr[31:ADDR_LSB]; in range iff word < NUM_REGS; index = word[$clog2(NUM_REGS)-1:0].
- COMMIT: if in range, update enabled bytes of regs[index], pulse wr_pulse, drive wr_index; wstrb = 0 is a legal write with no data change (pulse still fires). Out of range: no register change, no wr_pulse. Set bresp, assert bvalid, clear held flags, -> RESP.
- RESP: bvalid and bresp held stable until bvalid & bready; then bvalid = 0, -> IDLE.
- Only one write outstanding; no AW/W accepted while a response is pending.
- Reset (asserted any time, including mid-transaction): awready = 0 while reset low, then 1 from first cycle after release; wready likewise; bvalid = 0; bresp = 00; wr_pulse = 0; wr_index = 0; regs all 0; held flags cleared; state IDLE. Pending beats are dropped, no response issued.

## Timing
- AW and W handshaken on edge k (same edge): COMMIT during cycle k..k+1, bvalid high after edge k+1, regs updated after edge k+1.
- Split handshakes: latency counted from the later handshake edge, same as above.
- bvalid & bready on edge m: bvalid low after edge m; awready/wready high after edge m.
- Minimum back-to-back write period: 3 cycles (handshake, commit, response with bready held high).
- wr_pulse aligned with the cycle regs first shows new value.

## Configuration
- AXIL_WRITE_SLAVE_SLVERR_EN defined: out-of-range writes return bresp = 2'b10 (SLVERR).
- Undefined: out-of-range writes return bresp = 2'b00 (OKAY); write silently dropped. In-range behaviour identical in both builds.

## Test plan
- Reset release, AW addr 0x4 and W 0xDEADBEEF strb 4'hF same cycle, bready high -> bvalid one cycle after handshake, bresp 00, regs[1] = 0xDEADBEEF, wr_pulse once with wr_index 1.
- W (0x000000AA, strb 4'h1) three cycles before AW 0x8 -> wready drops after W, awready stays high; regs[2] = 0x000000AA, only byte 0 written, bvalid after AW handshake + 1.
- bready held low 5 cycles -> bvalid, bresp stable, awready/wready 0 throughout; new awvalid ignored until after B handshake.
- AW 0x20 with NUM_REGS = 8 -> regs unchanged, no wr_pulse; bresp 10 with AXIL_WRITE_SLAVE_SLVERR_EN, 00 without.
- Reset asserted after AW accepted, before W -> all outputs to reset values immediately; after release, fresh AW/W pair completes normally with single response.
- Back-to-back writes to 0x0..0x1C with bready high -> one write per 3 cycles, every register matches its written value.

Source files
------------

// File: rtl/axil_write_slave.sv
// AXI4-Lite write responder committing strobed data into a flat register bank.
// Define AXIL_WRITE_SLAVE_SLVERR_EN to answer out-of-range writes with SLVERR instead of OKAY.
module axil_write_slave #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_LSB = 2,
    localparam int unsigned IdxW = $clog2(NUM_REGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [31:0]             awaddr_i,
    input  logic [3:0]              awcache_i,
    input  logic [2:0]              awprot_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [31:0]             wdata_i,
    input  logic [3:0]              wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [32*NUM_REGS-1:0]  regs_o,
    output logic                    wr_pulse_o,
    output logic [IdxW-1:0]         wr_index_o
);

    localparam int unsigned WordW = 32 - ADDR_LSB;
    localparam logic [1:0] RespOkay = 2'b00;
`ifdef AXIL_WRITE_SLAVE_SLVERR_EN
    localparam logic [1:0] RespOor = 2'b10;
`else
    localparam logic [1:0] RespOor = 2'b00;
`endif

    typedef enum logic [1:0] {StIdle, StCommit, StResp} state_e;

    state_e                        state_q, state_d;
    logic                          aw_held_q, aw_held_d;
    logic                          w_held_q, w_held_d;
    logic [WordW-1:0]              word_q, word_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][31:0]     regs_q, regs_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          wr_pulse_q, wr_pulse_d;
    logic [IdxW-1:0]               wr_index_q, wr_index_d;
    logic                          aw_rdy, w_rdy;
    logic                          in_range;
    logic [IdxW-1:0]               idx;
    logic                          unused_sig;

    assign unused_sig = ^{awcache_i, awprot_i, awaddr_i[ADDR_LSB-1:0]};

    // NUM_REGS is a power of two, so in range means no word bits above the index field.
    assign in_range = (word_q >> IdxW) == '0;
    assign idx      = word_q[IdxW-1:0];

    always_comb begin
        state_d    = state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        regs_d     = regs_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_index_d = wr_index_q;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                aw_rdy = !aw_held_q;
                w_rdy  = !w_held_q;
                if (awvalid_i && aw_rdy) begin
                    aw_held_d = 1'b1;
                    word_d    = awaddr_i[31:ADDR_LSB];
                end
                if (wvalid_i && w_rdy) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata_i;
                    wstrb_d  = wstrb_i;
                end
                if (aw_held_d && w_held_d) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (in_range) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                    wr_pulse_d = 1'b1;
                    wr_index_d = idx;
                end
                bresp_d   = in_range ? RespOkay : RespOor;
                bvalid_d  = 1'b1;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                state_d   = StResp;
            end
            StResp: begin
                if (bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            regs_q     <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
        end else begin
            state_q    <= state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            regs_q     <= regs_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
        end
    end

    // Readies are forced low for the whole time reset is held.
    assign awready_o  = rst_ni & aw_rdy;
    assign wready_o   = rst_ni & w_rdy;
    assign bvalid_o   = bvalid_q;
    assign bresp_o    = bresp_q;
    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_index_o = wr_index_q;

endmodule

// File: tb/tb_axil_write_slave.sv
// Self-checking bench for axil_write_slave: directed plan plus randomized writes vs. a word-array model.
module tb_axil_write_slave;

    localparam int NREGS = 8;

`ifdef AXIL_WRITE_SLAVE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [31:0]           awaddr = '0;
    logic [3:0]            awcache = '0;
    logic [2:0]            awprot = '0;
    logic                  awvalid = 1'b0;
    logic                  awready;
    logic [31:0]           wdata = '0;
    logic [3:0]            wstrb = '0;
    logic                  wvalid = 1'b0;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready = 1'b0;
    logic [32*NREGS-1:0]   regs;
    logic                  wr_pulse;
    logic [2:0]            wr_index;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_edge = 0;
    logic [31:0] m_regs [NREGS];

    axil_write_slave #(.NUM_REGS(NREGS), .ADDR_LSB(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .awaddr_i   (awaddr),
        .awcache_i  (awcache),
        .awprot_i   (awprot),
        .awvalid_i  (awvalid),
        .awready_o  (awready),
        .wdata_i    (wdata),
        .wstrb_i    (wstrb),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .bresp_o    (bresp),
        .bvalid_o   (bvalid),
        .bready_i   (bready),
        .regs_o     (regs),
        .wr_pulse_o (wr_pulse),
        .wr_index_o (wr_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bank(input string tag);
        for (int k = 0; k < NREGS; k++) begin
            chk($sformatf("%s_reg%0d", tag, k), regs[32*k +: 32], m_regs[k]);
        end
    endtask

    // One complete AW/W/B transaction with configurable channel delays.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
        bit aw_done = 0;
        bit w_done = 0;
        bit hs_aw;
        bit hs_w;
        bit inr;
        int word;
        bready = 1'b0;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_done && (c >= w_dly);
            wdata   = data;
            wstrb   = strb;
            #1;
            chk({tag, "_awready"}, 32'(awready), 32'(!aw_done));
            chk({tag, "_wready"}, 32'(wready), 32'(!w_done));
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk);
            #1;
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            chk({tag, "_hs_timeout"}, 32'(aw_done && w_done), 32'd1);
            return;
        end
        hs_edge = cyc;
        chk({tag, "_commit_bvalid"}, 32'(bvalid), 32'd0);
        chk({tag, "_commit_awready"}, 32'(awready), 32'd0);
        chk({tag, "_commit_wready"}, 32'(wready), 32'd0);

        word = int'(addr >> 2);
        inr  = word < NREGS;
        if (inr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_regs[word][8*b +: 8] = data[8*b +: 8];
            end
        end
        tick();
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(inr ? 2'b00 : OOR_RESP));
        chk({tag, "_wr_pulse"}, 32'(wr_pulse), 32'(inr));
        if (inr) chk({tag, "_wr_index"}, 32'(wr_index), 32'(word));
        chk_bank(tag);

        for (int i = 0; i < b_dly; i++) begin
            awvalid = 1'b1;
            awaddr  = 32'h0000_0018;
            #1;
            chk({tag, "_stall_awready"}, 32'(awready), 32'd0);
            chk({tag, "_stall_wready"}, 32'(wready), 32'd0);
            chk({tag, "_stall_bvalid"}, 32'(bvalid), 32'd1);
            chk({tag, "_stall_bresp"}, 32'(bresp), 32'(inr ? 2'b00 : OOR_RESP));
            tick();
            chk({tag, "_stall_pulse"}, 32'(wr_pulse), 32'd0);
        end
        bready = 1'b1;
        tick();
        awvalid = 1'b0;
        bready  = 1'b0;
        chk({tag, "_b_done"}, 32'(bvalid), 32'd0);
        chk({tag, "_post_awready"}, 32'(awready), 32'd1);
        chk({tag, "_post_wready"}, 32'(wready), 32'd1);
        chk({tag, "_post_pulse"}, 32'(wr_pulse), 32'd0);
    endtask

    initial begin
        int prev;
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;

        // Reset held from time zero.
        #3;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_index", 32'(wr_index), 32'd0);
        chk_bank("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_wready", 32'(wready), 32'd1);
        chk("rel_bvalid", 32'(bvalid), 32'd0);

        do_write("same_cycle", 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_write("w_first", 32'h8, 32'h0000_00AA, 4'h1, 3, 0, 0);
        do_write("aw_first", 32'hC, 32'h1234_5678, 4'h6, 0, 2, 0);
        do_write("b_stall", 32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
        do_write("strb_zero", 32'hC, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        do_write("oor", 32'h20, 32'h5555_5555, 4'hF, 0, 0, 1);

        // Reset after AW accepted but before W arrives.
        awvalid = 1'b1;
        awaddr  = 32'h14;
        #1;
        tick();
        awvalid = 1'b0;
        chk("mid_aw_taken", 32'(awready), 32'd0);
        chk("mid_w_open", 32'(wready), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
        chk("mid_rst_awready", 32'(awready), 32'd0);
        chk("mid_rst_wready", 32'(wready), 32'd0);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rst_index", 32'(wr_index), 32'd0);
        chk_bank("mid_rst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b0;
            tick();
            chk("mid_no_resp", 32'(bvalid), 32'd0);
        end
        do_write("after_rst", 32'h14, 32'h0BAD_F00D, 4'hF, 1, 0, 0);

        // Back-to-back with bready high: one write every 3 cycles.
        for (int k = 0; k < NREGS; k++) begin
            prev = hs_edge;
            do_write($sformatf("b2b%0d", k), 32'(4 * k), $urandom, 4'hF, 0, 0, 0);
            if (k > 0) chk($sformatf("b2b%0d_period", k), 32'(hs_edge - prev), 32'd3);
        end

        for (int n = 0; n < 24; n++) begin
            do_write($sformatf("rnd%0d", n),
                     32'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3)),
                     $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
